load_store_unit: RTL and testbench

//   Data-side memory access stage between the core's execute path and a data bus.

---
 rtl/load_store_unit_if.sv | 42 ++++
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Purpose : bundles the core-side request/response handshake and the req/gnt/rvalid data bus.
// Latency : pure wiring, no storage.
// Backpressure: core side via req_valid/req_ready; bus side via mem_req held until mem_gnt.
// Ports   : req_* / rsp_* / stall (core side), mem_* (data bus side).
//           Modport slave is the load/store unit; modport master is whatever drives it.
interface load_store_unit_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_func3;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DWIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/load_store_unit.sv
// Purpose : data-side load/store stage; drives a req/gnt/rvalid bus, aligns and extends load data.
// Latency : accept->rsp_valid 3 cycles minimum (1 cycle for misaligned/illegal accesses).
// Backpressure: req_ready only in IDLE; stall high in REQ/WAIT; mem_req held until mem_gnt.
// Ports   : clk, rst (async active-low), bus (load_store_unit_if.slave).
module load_store_unit #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              lat_we;
    logic [2:0]        lat_func3;
    logic [1:0]        lat_off;

    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DWIDTH-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              stall_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [AWIDTH-1:0] mem_addr_q;
    logic [DWIDTH-1:0] mem_wdata_q;
    logic [3:0]        mem_be_q;

    logic [1:0]        in_off;
    logic              in_err;
    logic [DWIDTH-1:0] st_wdata;
    logic [3:0]        st_be;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DWIDTH-1:0] ld_ext;

    assign in_off = bus.req_addr[1:0];

    // Misalignment and illegal-encoding check on the incoming request.
    always_comb begin
        in_err = 1'b0;
        case (bus.req_func3)
            3'b000:  in_err = 1'b0;
            3'b001:  in_err = in_off[0];
            3'b010:  in_err = (in_off != 2'b00);
            3'b100:  in_err = bus.req_we;
            3'b101:  in_err = bus.req_we | in_off[0];
            default: in_err = 1'b1;
        endcase
    end

    // Lane replication and byte enables; loads use the same enables to mark the lanes read.
    always_comb begin
        st_wdata = bus.req_wdata;
        st_be    = 4'b1111;
        case (bus.req_func3[1:0])
            2'b00: begin
                st_wdata = {4{bus.req_wdata[7:0]}};
                st_be    = 4'b0001 << in_off;
            end
            2'b01: begin
                st_wdata = {2{bus.req_wdata[15:0]}};
                st_be    = 4'b0011 << in_off;
            end
            default: begin
                st_wdata = bus.req_wdata;
                st_be    = 4'b1111;
            end
        endcase
        if (!bus.req_we) st_wdata = '0;
    end

    // Load extraction from the returned word using the latched offset and width.
    always_comb begin
        ld_byte = bus.mem_rdata[7:0];
        case (lat_off)
            2'd0:    ld_byte = bus.mem_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = lat_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (lat_func3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_func3   <= '0;
            lat_off     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            stall_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        lat_we      <= bus.req_we;
                        lat_func3   <= bus.req_func3;
                        lat_off     <= in_off;
                        cnt         <= '0;
                        req_ready_q <= 1'b0;
                        if (in_err) begin
                            // Rejected without touching the bus.
                            state       <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state       <= S_REQ;
                            mem_req_q   <= 1'b1;
                            stall_q     <= 1'b1;
                            mem_we_q    <= bus.req_we;
                            mem_addr_q  <= {bus.req_addr[AWIDTH-1:2], 2'b00};
                            mem_wdata_q <= st_wdata;
                            mem_be_q    <= st_be;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_gnt) begin
                        state     <= S_WAIT;
                        mem_req_q <= 1'b0;
                        // Saturate so a grant on the last cycle cannot wrap the budget.
                        if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state       <= S_RESP;
                        mem_req_q   <= 1'b0;
                        stall_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        state       <= S_RESP;
                        stall_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= lat_we ? '0 : ld_ext;
                    end else if (cnt == CNT_LAST) begin
                        state       <= S_RESP;
                        stall_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state       <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.stall     = stall_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : directed self-checking bench for load_store_unit.
// Latency : inputs driven 1 ns after the rising edge, outputs sampled at the same point.
// Backpressure: bus grant/rvalid driven by hand per step.
module tb_load_store_unit;
    logic clk;
    logic rst;
    int   tests;
    int   failed;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request for one edge; returns in the cycle after accept.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_func3 = f3;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Grant now, return data next cycle; returns in the RESP cycle.
    task automatic complete(input logic [31:0] rdata);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rdata, input logic [31:0] exp);
        issue(1'b0, f3, addr, 32'h0);
        complete(rdata);
        check({tag, "_valid"}, bus.rsp_valid, 1);
        check({tag, "_rdata"}, bus.rsp_rdata, exp);
        check({tag, "_err"}, bus.rsp_err, 0);
        tick();
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_func3  = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        tick();
        tick();
        check("rst_ready", bus.req_ready, 1);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_rdata", bus.rsp_rdata, 32'h0);
        check("rst_be", {28'd0, bus.mem_be}, 32'h0);
        rst = 1'b1;
        tick();

        // LW 0x100, minimum latency
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        check("lw_req", bus.mem_req, 1);
        check("lw_addr", bus.mem_addr, 32'h100);
        check("lw_be", {28'd0, bus.mem_be}, 32'hF);
        check("lw_we", bus.mem_we, 0);
        check("lw_stall_c1", bus.stall, 1);
        check("lw_ready_c1", bus.req_ready, 0);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        check("lw_req_c2", bus.mem_req, 0);
        check("lw_stall_c2", bus.stall, 1);
        check("lw_valid_c2", bus.rsp_valid, 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEADBEEF;
        tick();
        bus.mem_rvalid = 1'b0;
        check("lw_valid_c3", bus.rsp_valid, 1);
        check("lw_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        check("lw_err", bus.rsp_err, 0);
        check("lw_stall_c3", bus.stall, 0);
        check("lw_ready_c3", bus.req_ready, 0);
        tick();
        check("lw_valid_c4", bus.rsp_valid, 0);
        check("lw_ready_c4", bus.req_ready, 1);
        check("lw_rdata_hold", bus.rsp_rdata, 32'hDEADBEEF);

        // Sub-word loads from 0x80FF1234
        load_check("lb103", 3'b000, 32'h103, 32'h80FF1234, 32'hFFFFFF80);
        load_check("lbu103", 3'b100, 32'h103, 32'h80FF1234, 32'h00000080);
        load_check("lh102", 3'b001, 32'h102, 32'h80FF1234, 32'hFFFF80FF);
        load_check("lhu100", 3'b101, 32'h100, 32'h80FF1234, 32'h00001234);
        load_check("lb101", 3'b000, 32'h101, 32'h80FF1234, 32'h00000012);

        // Error accesses: no bus activity, response in cycle 1
        issue(1'b0, 3'b010, 32'h102, 32'h0);
        check("lw_mis_req", bus.mem_req, 0);
        check("lw_mis_valid", bus.rsp_valid, 1);
        check("lw_mis_err", bus.rsp_err, 1);
        check("lw_mis_rdata", bus.rsp_rdata, 32'h0);
        check("lw_mis_stall", bus.stall, 0);
        tick();
        check("lw_mis_ready", bus.req_ready, 1);
        issue(1'b0, 3'b001, 32'h101, 32'h0);
        check("lh_mis_req", bus.mem_req, 0);
        check("lh_mis_err", {bus.rsp_valid, bus.rsp_err}, 32'h3);
        tick();
        issue(1'b0, 3'b011, 32'h100, 32'h0);
        check("f3_011_err", {bus.rsp_valid, bus.rsp_err, bus.mem_req}, 32'h6);
        tick();
        issue(1'b1, 3'b100, 32'h100, 32'h0);
        check("sbu_err", {bus.rsp_valid, bus.rsp_err, bus.mem_req}, 32'h6);
        tick();

        // Stores
        issue(1'b1, 3'b000, 32'h101, 32'h000000A5);
        check("sb_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        check("sb_be", {28'd0, bus.mem_be}, 32'h2);
        check("sb_we", bus.mem_we, 1);
        check("sb_addr", bus.mem_addr, 32'h100);
        complete(32'hFFFFFFFF);
        check("sb_valid", bus.rsp_valid, 1);
        check("sb_rdata", bus.rsp_rdata, 32'h0);
        check("sb_err", bus.rsp_err, 0);
        tick();
        issue(1'b1, 3'b001, 32'h102, 32'h00001234);
        check("sh_wdata", bus.mem_wdata, 32'h12341234);
        check("sh_be", {28'd0, bus.mem_be}, 32'hC);
        complete(32'h0);
        tick();
        issue(1'b1, 3'b010, 32'h104, 32'hCAFEF00D);
        check("sw_wdata", bus.mem_wdata, 32'hCAFEF00D);
        check("sw_be", {28'd0, bus.mem_be}, 32'hF);
        check("sw_addr", bus.mem_addr, 32'h104);
        complete(32'h0);
        tick();

        // rvalid in the grant cycle is ignored
        issue(1'b0, 3'b010, 32'h600, 32'h0);
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h55555555;
        tick();
        bus.mem_gnt = 1'b0;
        check("gnt_rv_valid", bus.rsp_valid, 0);
        check("gnt_rv_stall", bus.stall, 1);
        bus.mem_rdata = 32'h66666666;
        tick();
        bus.mem_rvalid = 1'b0;
        check("gnt_rv_rdata", bus.rsp_rdata, 32'h66666666);
        tick();

        // Grant withheld 5 cycles, then normal completion
        issue(1'b0, 3'b010, 32'h200, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_req", bus.mem_req, 1);
            check("hold_addr", bus.mem_addr, 32'h200);
            check("hold_stall", bus.stall, 1);
        end
        complete(32'h11223344);
        check("hold_valid", bus.rsp_valid, 1);
        check("hold_rdata", bus.rsp_rdata, 32'h11223344);
        check("hold_err", bus.rsp_err, 0);
        tick();

        // No grant: timeout after 16 cycles in REQ
        issue(1'b0, 3'b010, 32'h300, 32'h0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_req", {bus.mem_req, bus.rsp_valid}, 32'h2);
        end
        tick();
        check("to_valid", bus.rsp_valid, 1);
        check("to_err", bus.rsp_err, 1);
        check("to_req_low", bus.mem_req, 0);
        check("to_rdata", bus.rsp_rdata, 32'h0);
        check("to_stall", bus.stall, 0);
        tick();
        check("to_ready", bus.req_ready, 1);

        // Reset during WAIT
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        check("rw_in_wait", bus.stall, 1);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h77777777;
        #1;
        check("rw_ready", bus.req_ready, 1);
        check("rw_req", bus.mem_req, 0);
        check("rw_stall", bus.stall, 0);
        check("rw_valid", bus.rsp_valid, 0);
        tick();
        check("rw_valid_2", bus.rsp_valid, 0);
        bus.mem_rvalid = 1'b0;
        rst = 1'b1;
        tick();
        check("rw_valid_3", bus.rsp_valid, 0);
        check("rw_ready_2", bus.req_ready, 1);
        load_check("post_rst_lw", 3'b010, 32'h500, 32'h0BADF00D, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
